// File: rtl/riscv_state_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter values, the
// table-initialisation state enum and the saturating counter update.
package riscv_state_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    function automatic logic [1:0] bp_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != BP_ST) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != BP_SNT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Generic one-read/one-write synchronous RAM with optional write-first bypass.
// Kept separate so a technology macro can replace the behavioural array.
module rl_ram_1r1w #(
    parameter int ABITS       = 10,
    parameter int DBITS       = 32,
    parameter int WRITE_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DBITS-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DBITS-1:0] rdata_o
);

    logic [DBITS-1:0] mem_q [2**ABITS];
    logic [DBITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            // Same-address write in this cycle wins over the stored value.
            if (WRITE_FIRST != 0 && we_i && waddr_i == raddr_i) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_bp_bht.sv
// Global-history branch history table: fills itself with weakly-not-taken
// after reset, then serves 1-cycle predictions and trains from the branch unit.
module riscv_bp_bht
    import riscv_state_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10,
    parameter int HAS_RVC        = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      if_stall,
    input  logic [XLEN-1:0]           if_pc,
    input  logic [XLEN-1:0]           bu_pc,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
    input  logic [1:0]                bu_bp_predict,
    input  logic                      bu_bp_btaken,
    input  logic                      bu_bp_update,
    output logic [1:0]                bp_bp_predict,
    output logic                      bp_init_busy
);

    localparam int ABITS  = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int PC_LSB = (HAS_RVC != 0) ? 1 : 2;

    bp_state_e        state_q, state_d;
    logic [ABITS-1:0] init_cnt_q, init_cnt_d;
    logic             rd_valid_q, rd_valid_d;

    logic [ABITS-1:0] rd_idx, upd_idx;
    logic [1:0]       upd_value;
    logic             ram_we;
    logic [ABITS-1:0] ram_waddr;
    logic [1:0]       ram_wdata;
    logic [1:0]       ram_rdata;
    logic             unused_pc_bits;

    assign rd_idx    = {bu_bp_history, if_pc[PC_LSB +: BP_LOCAL_BITS]};
    assign upd_idx   = {bu_bp_history, bu_pc[PC_LSB +: BP_LOCAL_BITS]};
    assign upd_value = bp_sat_update(bu_bp_predict, bu_bp_btaken);
    assign unused_pc_bits = ^{if_pc, bu_pc};

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rd_valid_d = rd_valid_q;
        ram_we     = 1'b0;
        ram_waddr  = upd_idx;
        ram_wdata  = upd_value;
        case (state_q)
            BP_INIT: begin
                // Branch-unit updates are dropped while the table is filled.
                ram_we     = 1'b1;
                ram_waddr  = init_cnt_q;
                ram_wdata  = BP_WNT;
                init_cnt_d = init_cnt_q + ABITS'(1);
                if (init_cnt_q == '1) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                ram_we = bu_bp_update;
            end
            default: begin
                state_d = BP_INIT;
            end
        endcase
        // Prediction is only trusted when the read was captured in RUN.
        if (!if_stall) begin
            rd_valid_d = (state_q == BP_RUN);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= BP_INIT;
            init_cnt_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    rl_ram_1r1w #(
        .ABITS      (ABITS),
        .DBITS      (2),
        .WRITE_FIRST(1)
    ) u_table (
        .clk_i  (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .re_i   (!if_stall),
        .raddr_i(rd_idx),
        .rdata_o(ram_rdata)
    );

    assign bp_bp_predict = rd_valid_q ? ram_rdata : BP_SNT;
    assign bp_init_busy  = (state_q == BP_INIT);

endmodule

// File: tb/tb_riscv_bp_bht.sv
// Bench for riscv_bp_bht: two instances (word-aligned and RVC PC fields)
// share stimulus and are compared every cycle against a table-level model.
module tb_riscv_bp_bht;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_stall;
    logic [31:0] if_pc;
    logic [31:0] bu_pc;
    logic [1:0]  bu_bp_history;
    logic [1:0]  bu_bp_predict;
    logic        bu_bp_btaken;
    logic        bu_bp_update;
    logic [1:0]  pred0, pred1;
    logic        busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    riscv_bp_bht #(.HAS_RVC(0)) dut0 (
        .clk(clk), .rstn(rstn), .if_stall(if_stall), .if_pc(if_pc), .bu_pc(bu_pc),
        .bu_bp_history(bu_bp_history), .bu_bp_predict(bu_bp_predict),
        .bu_bp_btaken(bu_bp_btaken), .bu_bp_update(bu_bp_update),
        .bp_bp_predict(pred0), .bp_init_busy(busy0)
    );

    riscv_bp_bht #(.HAS_RVC(1)) dut1 (
        .clk(clk), .rstn(rstn), .if_stall(if_stall), .if_pc(if_pc), .bu_pc(bu_pc),
        .bu_bp_history(bu_bp_history), .bu_bp_predict(bu_bp_predict),
        .bu_bp_btaken(bu_bp_btaken), .bu_bp_update(bu_bp_update),
        .bp_bp_predict(pred1), .bp_init_busy(busy1)
    );

    // ---------------- reference model ----------------
    logic [1:0] t0 [DEPTH];
    logic [1:0] t1 [DEPTH];
    logic [1:0] e0, e1;
    int         init_n;

    function automatic int bidx(input logic [31:0] pc, input logic [1:0] h, input int rvc);
        return int'(h) * 1024 + int'((pc >> (rvc != 0 ? 1 : 2)) & 32'h3FF);
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] p, input logic t);
        if (t) return (p == 2'd3) ? p : p + 2'd1;
        return (p == 2'd0) ? p : p - 2'd1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_n <= 0;
            e0     <= 2'd0;
            e1     <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                t0[i] <= 2'd1;
                t1[i] <= 2'd1;
            end
        end else if (init_n < DEPTH) begin
            init_n <= init_n + 1;
            e0     <= 2'd0;
            e1     <= 2'd0;
        end else begin
            if (!if_stall) begin
                e0 <= (bu_bp_update && bidx(bu_pc, bu_bp_history, 0) == bidx(if_pc, bu_bp_history, 0))
                      ? sat(bu_bp_predict, bu_bp_btaken) : t0[bidx(if_pc, bu_bp_history, 0)];
                e1 <= (bu_bp_update && bidx(bu_pc, bu_bp_history, 1) == bidx(if_pc, bu_bp_history, 1))
                      ? sat(bu_bp_predict, bu_bp_btaken) : t1[bidx(if_pc, bu_bp_history, 1)];
            end
            if (bu_bp_update) begin
                t0[bidx(bu_pc, bu_bp_history, 0)] <= sat(bu_bp_predict, bu_bp_btaken);
                t1[bidx(bu_pc, bu_bp_history, 1)] <= sat(bu_bp_predict, bu_bp_btaken);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pred0_vs_model", 32'(pred0), 32'(e0));
            check("pred1_vs_model", 32'(pred1), 32'(e1));
            check("busy0_vs_model", 32'(busy0), 32'(init_n < DEPTH));
            check("busy1_vs_model", 32'(busy1), 32'(init_n < DEPTH));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic stall, input logic upd,
                         input logic [31:0] upc, input logic [1:0] p, input logic tk,
                         input logic [1:0] h);
        if_pc         = pc;
        if_stall      = stall;
        bu_bp_update  = upd;
        bu_pc         = upc;
        bu_bp_predict = p;
        bu_bp_btaken  = tk;
        bu_bp_history = h;
    endtask

    // Counts edges until busy drops, pulsing updates that must be ignored.
    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (cnt < 5000) begin
            drive(32'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h400, 2'd3, 1'b1, 2'd0);
            tick();
            cnt++;
            if (!busy0) break;
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        check(name, 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        rstn = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_busy", 32'(busy0), 32'd1);
        check("reset_pred", 32'(pred0), 32'd0);
        rstn = 1'b1;
        wait_init("init_len_first");

        drive(32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("first_read_wnt", 32'(pred0), 32'd1);

        drive(32'h0, 1'b0, 1'b1, 32'h200, 2'd1, 1'b1, 2'd0);
        tick();
        drive(32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("upd_01_taken", 32'(pred0), 32'd2);

        drive(32'h0, 1'b0, 1'b1, 32'h200, 2'd3, 1'b1, 2'd0);
        tick();
        drive(32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("upd_11_saturate", 32'(pred0), 32'd3);

        drive(32'h0, 1'b0, 1'b1, 32'h200, 2'd0, 1'b0, 2'd0);
        tick();
        drive(32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("upd_00_floor", 32'(pred0), 32'd0);

        drive(32'h240, 1'b0, 1'b1, 32'h240, 2'd2, 1'b1, 2'd0);
        tick();
        check("collision_fwd", 32'(pred0), 32'd3);

        drive(32'h300, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("pre_stall_read", 32'(pred0), 32'd1);
        drive(32'h200, 1'b1, 1'b1, 32'h300, 2'd1, 1'b1, 2'd0);
        tick();
        check("stall_hold_0", 32'(pred0), 32'd1);
        drive(32'h240, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("stall_hold_1", 32'(pred0), 32'd1);
        drive(32'h204, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("stall_hold_2", 32'(pred0), 32'd1);
        drive(32'h300, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("stall_upd_visible", 32'(pred0), 32'd2);

        for (int i = 0; i < 1500; i++) begin
            drive((32'($urandom) & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 1),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  (32'($urandom) & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 1),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
        end

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            drive(32'h200, 1'b0, 1'($urandom_range(0, 1)), 32'h200, 2'd3, 1'b1, 2'd0);
            tick();
        end
        rstn = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        tick();
        check("midinit_reset_busy", 32'(busy0), 32'd1);
        rstn = 1'b1;
        wait_init("init_len_restart");

        drive(32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("init_drop_200", 32'(pred0), 32'd1);
        drive(32'h400, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("init_drop_400", 32'(pred0), 32'd1);

        drive(32'h0, 1'b0, 1'b1, 32'h202, 2'd2, 1'b1, 2'd0);
        tick();
        drive(32'h0, 1'b0, 1'b1, 32'h200, 2'd1, 1'b0, 2'd0);
        tick();
        drive(32'h202, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("rvc_read_202", 32'(pred1), 32'd3);
        check("norvc_read_202", 32'(pred0), 32'd0);
        drive(32'h200, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("rvc_read_200", 32'(pred1), 32'd0);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
